// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multi-cycle RV64 main controller: state
// encodings, opcode constants, datapath select encodings and the bundle of
// control strobes driven toward the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_ALU_WB   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_TRAP     = 4'd10
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_type;
    logic       illegal_instr;
  } ctrl_t;

  // States in which the controller waits on the memory handshake.
  function automatic logic is_mem_state(state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
// Purely combinational state -> control-strobe decoder (Moore outputs, with
// the handshake-qualified strobes gated by mem_ready / zero).
// Ports:
//   i_state      current controller state
//   i_opcode     IR[6:0], selects S vs I immediate in MEM_ADDR
//   i_zero       ALU zero flag, qualifies the branch PC load
//   i_mem_ready  memory handshake, qualifies the FETCH IR/PC update
//   o_ctrl       bundle of datapath control strobes
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [6:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = ALUB_FOUR;
        o_ctrl.alu_op    = ALU_OP_ADD;
        // IR and PC only update on the cycle the fetch completes.
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_en     = i_mem_ready;
      end
      ST_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        o_ctrl.alu_src_b = ALUB_IMM;
        o_ctrl.imm_type  = IMM_B;
        o_ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_REG;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_IMM;
        o_ctrl.imm_type  = IMM_I;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_ALU_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      ST_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_IMM;
        o_ctrl.alu_op    = ALU_OP_ADD;
        o_ctrl.imm_type  = (i_opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      ST_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ALUB_REG;
        o_ctrl.alu_op    = ALU_OP_SUB;
        o_ctrl.pc_src    = 1'b1;
        o_ctrl.pc_en     = i_zero;
      end
      ST_TRAP: begin
        o_ctrl.illegal_instr = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Main controller sequencing a multi-cycle RV64 datapath for R-type, I-ALU,
// ld, sd and beq. Holds the state register, next-state logic, the memory
// wait watchdog and the retired-instruction counter.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_opcode, i_funct3      IR fields, valid from DECODE onward
//   i_zero                  ALU zero flag
//   i_mem_ready             memory completes the current access this cycle
//   o_pc_en .. o_imm_type   datapath control strobes (all 0 while in reset)
//   o_illegal_instr         one-cycle pulse on unsupported instruction
//   o_mem_timeout           one-cycle pulse when a memory wait hits WAIT_LIMIT
//   o_retired               retired-instruction count (wraps silently)
//   o_state_dbg             current state encoding
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4 -> PC when memory is ready
// DECODE    | dispatch on opcode, precompute branch target into ALUOut
// EXEC_R    | reg A op reg B
// EXEC_I    | reg A op I-immediate
// ALU_WB    | write ALUOut to rd, retire
// MEM_ADDR  | reg A + immediate -> effective address
// MEM_RD    | load access, wait for mem_ready
// MEM_WB    | write MDR to rd, retire
// MEM_WR    | store access, retire when mem_ready
// BRANCH    | compare, load branch target if zero, retire
// TRAP      | flag illegal instruction, resume at next instruction
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int RETIRE_W   = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_pc_en,
  output logic                o_pc_src,
  output logic                o_ir_write,
  output logic                o_i_or_d,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_reg_write,
  output logic                o_mem_to_reg,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_alu_op,
  output logic [1:0]          o_imm_type,
  output logic                o_illegal_instr,
  output logic                o_mem_timeout,
  output logic [RETIRE_W-1:0] o_retired,
  output logic [3:0]          o_state_dbg
);

  // Counter only needs to hold 0 .. WAIT_LIMIT-1; it clears on the limit cycle.
  localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT - 1);

  state_e              r_state;
  state_e              w_next;
  logic [RETIRE_W-1:0] r_retired;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_waiting;
  logic                w_timeout;
  logic                w_wait_inc;
  logic                w_retire;
  ctrl_t               w_dec;
  ctrl_t               w_ctrl;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_FETCH;
      r_retired <= '0;
      r_wait    <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
      if (w_wait_inc) begin
        r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      ST_FETCH:    if (i_mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        if (i_opcode == OP_R) begin
          w_next = ST_EXEC_R;
        end else if (i_opcode == OP_IMM) begin
          w_next = ST_EXEC_I;
        end else if ((i_opcode == OP_LOAD) || (i_opcode == OP_STORE)) begin
          w_next = ST_MEM_ADDR;
        end else if ((i_opcode == OP_BRANCH) && (i_funct3 == F3_BEQ)) begin
          w_next = ST_BRANCH;
        end else begin
          w_next = ST_TRAP;
        end
      end
      ST_EXEC_R:   w_next = ST_ALU_WB;
      ST_EXEC_I:   w_next = ST_ALU_WB;
      ST_ALU_WB: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_MEM_ADDR: w_next = (i_opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (i_mem_ready) w_next = ST_MEM_WB;
      ST_MEM_WB: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_MEM_WR: begin
        if (i_mem_ready) begin
          w_next   = ST_FETCH;
          w_retire = 1'b1;
        end
      end
      ST_BRANCH: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_TRAP:     w_next = ST_FETCH;
      default:     w_next = ST_FETCH;
    endcase
  end

  // The watchdog only reports; the FSM keeps waiting after a timeout.
  assign w_waiting  = is_mem_state(r_state) && !i_mem_ready;
  assign w_timeout  = w_waiting && (r_wait == WAIT_MAX);
  assign w_wait_inc = w_waiting && !w_timeout && (w_next == r_state);

  mc_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (i_opcode),
    .i_zero      (i_zero),
    .i_mem_ready (i_mem_ready),
    .o_ctrl      (w_dec)
  );

  // Reset silences every strobe in the same cycle it is asserted.
  assign w_ctrl = i_reset ? '0 : w_dec;

  assign o_pc_en         = w_ctrl.pc_en;
  assign o_pc_src        = w_ctrl.pc_src;
  assign o_ir_write      = w_ctrl.ir_write;
  assign o_i_or_d        = w_ctrl.i_or_d;
  assign o_mem_read      = w_ctrl.mem_read;
  assign o_mem_write     = w_ctrl.mem_write;
  assign o_reg_write     = w_ctrl.reg_write;
  assign o_mem_to_reg    = w_ctrl.mem_to_reg;
  assign o_alu_src_a     = w_ctrl.alu_src_a;
  assign o_alu_src_b     = w_ctrl.alu_src_b;
  assign o_alu_op        = w_ctrl.alu_op;
  assign o_imm_type      = w_ctrl.imm_type;
  assign o_illegal_instr = w_ctrl.illegal_instr;
  assign o_mem_timeout   = w_timeout && !i_reset;
  assign o_retired       = r_retired;
  assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
// Table-driven per-cycle vectors plus hand-written sequences for the fetch
// watchdog and the retired-counter wrap.
module tb_multicycle_control_fsm;

  localparam int RW = 4;

  localparam logic [3:0] F  = 4'd0;
  localparam logic [3:0] D  = 4'd1;
  localparam logic [3:0] XR = 4'd2;
  localparam logic [3:0] XI = 4'd3;
  localparam logic [3:0] AW = 4'd4;
  localparam logic [3:0] MA = 4'd5;
  localparam logic [3:0] MR = 4'd6;
  localparam logic [3:0] MW = 4'd7;
  localparam logic [3:0] WR = 4'd8;
  localparam logic [3:0] BR = 4'd9;
  localparam logic [3:0] TR = 4'd10;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write;
  logic          reg_write, mem_to_reg, alu_src_a, illegal_instr, mem_timeout;
  logic [1:0]    alu_src_b, alu_op, imm_type;
  logic [RW-1:0] retired;
  logic [3:0]    state_dbg;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.RETIRE_W(RW), .WAIT_LIMIT(4)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_opcode        (opcode),
    .i_funct3        (funct3),
    .i_zero          (zero),
    .i_mem_ready     (mem_ready),
    .o_pc_en         (pc_en),
    .o_pc_src        (pc_src),
    .o_ir_write      (ir_write),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_reg_write     (reg_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_imm_type      (imm_type),
    .o_illegal_instr (illegal_instr),
    .o_mem_timeout   (mem_timeout),
    .o_retired       (retired),
    .o_state_dbg     (state_dbg)
  );

  // Expected strobe word: {pc_en, pc_src, ir_write, i_or_d, mem_read,
  // mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
  // imm_type, illegal_instr, mem_timeout}
  function automatic logic [16:0] mk(logic pe, logic ps, logic ir, logic iod,
                                     logic mr, logic mw, logic rw, logic m2r,
                                     logic a, logic [1:0] b, logic [1:0] op,
                                     logic [1:0] imm, logic ill, logic to);
    return {pe, ps, ir, iod, mr, mw, rw, m2r, a, b, op, imm, ill, to};
  endfunction

  function automatic logic [16:0] act_word();
    return {pc_en, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_type, illegal_instr,
            mem_timeout};
  endfunction

  typedef struct {
    string       nm;
    logic        rst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [RW-1:0] ret;
  } vec_t;

  vec_t vecs[$];

  task automatic push(string nm, logic rst, logic [6:0] opc, logic [2:0] f3,
                      logic z, logic rdy, logic [3:0] st, logic [16:0] ctl,
                      logic [RW-1:0] ret);
    vec_t v;
    v.nm = nm; v.rst = rst; v.opc = opc; v.f3 = f3; v.z = z; v.rdy = rdy;
    v.st = st; v.ctl = ctl; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  logic [16:0] C_ZERO, C_FWAIT, C_FGO, C_DEC, C_XR, C_XI, C_AWB, C_MALD,
               C_MAST, C_MRD, C_MWB, C_MWR, C_MWR_TO, C_BRT, C_BRN, C_TRAP;

  initial begin
    //               pe   ps   ir   iod  mr   mw   rw   m2r  a    b      op     imm    ill  to
    C_ZERO   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    C_FWAIT  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
    C_FGO    = mk(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
    C_DEC    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b0,1'b0);
    C_XR     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0);
    C_XI     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,2'b00,1'b0,1'b0);
    C_AWB    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    C_MALD   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
    C_MAST   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b01,1'b0,1'b0);
    C_MRD    = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    C_MWB    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    C_MWR    = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
    C_MWR_TO = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1);
    C_BRT    = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00,1'b0,1'b0);
    C_BRN    = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00,1'b0,1'b0);
    C_TRAP   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);

    //   name        rst   opc      f3     z     rdy   st  ctl      ret
    for (int i = 0; i < 3; i++)
      push("reset",  1'b1, OPC_R,   3'd0, 1'b0, 1'b1, F,  C_ZERO,  4'd0);
    push("add_f",    1'b0, OPC_R,   3'd0, 1'b0, 1'b1, F,  C_FGO,   4'd0);
    push("add_d",    1'b0, OPC_R,   3'd0, 1'b0, 1'b1, D,  C_DEC,   4'd0);
    push("add_x",    1'b0, OPC_R,   3'd0, 1'b0, 1'b1, XR, C_XR,    4'd0);
    push("add_wb",   1'b0, OPC_R,   3'd0, 1'b0, 1'b1, AW, C_AWB,   4'd0);
    push("ld_f",     1'b0, OPC_LD,  3'd3, 1'b0, 1'b1, F,  C_FGO,   4'd1);
    push("ld_d",     1'b0, OPC_LD,  3'd3, 1'b0, 1'b1, D,  C_DEC,   4'd1);
    push("ld_ma",    1'b0, OPC_LD,  3'd3, 1'b0, 1'b1, MA, C_MALD,  4'd1);
    for (int i = 0; i < 3; i++)
      push("ld_rdw", 1'b0, OPC_LD,  3'd3, 1'b0, 1'b0, MR, C_MRD,   4'd1);
    push("ld_rd",    1'b0, OPC_LD,  3'd3, 1'b0, 1'b1, MR, C_MRD,   4'd1);
    push("ld_wb",    1'b0, OPC_LD,  3'd3, 1'b0, 1'b1, MW, C_MWB,   4'd1);
    push("sd_f",     1'b0, OPC_SD,  3'd3, 1'b0, 1'b1, F,  C_FGO,   4'd2);
    push("sd_d",     1'b0, OPC_SD,  3'd3, 1'b0, 1'b1, D,  C_DEC,   4'd2);
    push("sd_ma",    1'b0, OPC_SD,  3'd3, 1'b0, 1'b1, MA, C_MAST,  4'd2);
    push("sd_wr",    1'b0, OPC_SD,  3'd3, 1'b0, 1'b1, WR, C_MWR,   4'd2);
    push("addi_f",   1'b0, OPC_I,   3'd0, 1'b0, 1'b1, F,  C_FGO,   4'd3);
    push("addi_d",   1'b0, OPC_I,   3'd0, 1'b0, 1'b1, D,  C_DEC,   4'd3);
    push("addi_x",   1'b0, OPC_I,   3'd0, 1'b0, 1'b1, XI, C_XI,    4'd3);
    push("addi_wb",  1'b0, OPC_I,   3'd0, 1'b0, 1'b1, AW, C_AWB,   4'd3);
    push("beqt_f",   1'b0, OPC_BR,  3'd0, 1'b1, 1'b1, F,  C_FGO,   4'd4);
    push("beqt_d",   1'b0, OPC_BR,  3'd0, 1'b1, 1'b1, D,  C_DEC,   4'd4);
    push("beqt_br",  1'b0, OPC_BR,  3'd0, 1'b1, 1'b1, BR, C_BRT,   4'd4);
    push("beqn_f",   1'b0, OPC_BR,  3'd0, 1'b0, 1'b1, F,  C_FGO,   4'd5);
    push("beqn_d",   1'b0, OPC_BR,  3'd0, 1'b0, 1'b1, D,  C_DEC,   4'd5);
    push("beqn_br",  1'b0, OPC_BR,  3'd0, 1'b0, 1'b1, BR, C_BRN,   4'd5);
    push("bad_f",    1'b0, OPC_BAD, 3'd0, 1'b0, 1'b1, F,  C_FGO,   4'd6);
    push("bad_d",    1'b0, OPC_BAD, 3'd0, 1'b0, 1'b1, D,  C_DEC,   4'd6);
    push("bad_trap", 1'b0, OPC_BAD, 3'd0, 1'b0, 1'b1, TR, C_TRAP,  4'd6);
    push("bne_f",    1'b0, OPC_BR,  3'd1, 1'b1, 1'b1, F,  C_FGO,   4'd6);
    push("bne_d",    1'b0, OPC_BR,  3'd1, 1'b1, 1'b1, D,  C_DEC,   4'd6);
    push("bne_trap", 1'b0, OPC_BR,  3'd1, 1'b1, 1'b1, TR, C_TRAP,  4'd6);
    push("f_hold",   1'b0, OPC_SD,  3'd3, 1'b0, 1'b0, F,  C_FWAIT, 4'd6);
    push("sd2_f",    1'b0, OPC_SD,  3'd3, 1'b0, 1'b1, F,  C_FGO,   4'd6);
    push("sd2_d",    1'b0, OPC_SD,  3'd3, 1'b0, 1'b1, D,  C_DEC,   4'd6);
    push("sd2_ma",   1'b0, OPC_SD,  3'd3, 1'b0, 1'b1, MA, C_MAST,  4'd6);
    for (int i = 1; i <= 10; i++)
      push("sd2_wait", 1'b0, OPC_SD, 3'd3, 1'b0, 1'b0, WR,
           (i == 4 || i == 8) ? C_MWR_TO : C_MWR, 4'd6);
    push("sd2_rst",  1'b1, OPC_SD,  3'd3, 1'b0, 1'b0, WR, C_ZERO,  4'd6);
    push("post_rst", 1'b0, OPC_R,   3'd0, 1'b0, 1'b1, F,  C_FGO,   4'd0);

    reset = 1'b1; opcode = OPC_R; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst; opcode = vecs[k].opc; funct3 = vecs[k].f3;
      zero = vecs[k].z; mem_ready = vecs[k].rdy;
      #1;
      chk({vecs[k].nm, "_state"}, 32'(state_dbg), 32'(vecs[k].st));
      chk({vecs[k].nm, "_ctrl"},  32'(act_word()), 32'(vecs[k].ctl));
      chk({vecs[k].nm, "_ret"},   32'(retired), 32'(vecs[k].ret));
    end

    // Fetch stall past the watchdog limit: pulse on 4th low cycle, no abort.
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("fstall_state", 32'(state_dbg), 32'(F));
      chk("fstall_ctrl", 32'(act_word()),
          32'((i == 3) ? (C_FWAIT | 17'd1) : C_FWAIT));
      @(negedge clk);
    end

    // Sixteen not-taken beqs: retired walks 0..15 and wraps back to 0.
    for (int k = 0; k <= 16; k++) begin
      opcode = OPC_BR; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
      #1;
      chk("wrap_ret", 32'(retired), 32'(k % 16));
      if (k == 16) break;
      chk("wrap_f", 32'(state_dbg), 32'(F));
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("wrap_br", 32'(act_word()), 32'(C_BRN));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
